// File: rtl/fuse_loader.sv
// fuse_loader
//   Serial configuration loader for the product-term fuse bitmap of one logic
//   block. A bit-serial stream (valid/ready) is assembled LSB-first into a
//   ROW_WIDTH-bit shadow row. Each complete row is then committed atomically
//   into the registered fuse array that drives ptbitmap_mux.
//
//   Optional feature macro: FUSE_LOADER_PARITY_EN
//     defined   - every row is followed by one even-parity bit; a mismatch sets
//                 the sticky error flag and aborts the load (remaining rows stay
//                 erased).
//     undefined - no parity bit, SHIFT goes straight to COMMIT, error tied to 0.
//
//   Ports
//     clk, rst      clock (rising edge), asynchronous active-high reset
//     start         erase + reload request, honoured only in IDLE or DONE
//     cfg_valid     stream bit valid
//     cfg_bit       stream data bit
//     cfg_ready     loader accepts a bit (transfer on cfg_valid & cfg_ready)
//     ptbitmap_mux  fuse array, row r bit i at index r*ROW_WIDTH+i (erased = 1)
//     row_idx       row currently being loaded
//     busy          high in ERASE / SHIFT / PARITY / COMMIT
//     done          high in DONE
//     error         sticky parity error, cleared by ERASE or reset
module fuse_loader #(
  parameter int ROWS      = 80,
  parameter int ROW_WIDTH = 96,
  parameter int IDX_W     = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      cfg_valid,
  input  logic                      cfg_bit,
  output logic                      cfg_ready,
  output logic [ROWS*ROW_WIDTH-1:0] ptbitmap_mux,
  output logic [IDX_W-1:0]          row_idx,
  output logic                      busy,
  output logic                      done,
  output logic                      error
);

  localparam int CNT_W = (ROW_WIDTH > 1) ? $clog2(ROW_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ERASE  = 3'd1,
    S_SHIFT  = 3'd2,
`ifdef FUSE_LOADER_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_COMMIT = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                    state_q, state_d;
  logic [ROWS*ROW_WIDTH-1:0] fuse_q, fuse_d;
  logic [ROW_WIDTH-1:0]      shadow_q, shadow_d;
  logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]          row_idx_q, row_idx_d;
  logic                      cfg_ready_q, cfg_ready_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      xfer;
`ifdef FUSE_LOADER_PARITY_EN
  logic                      error_q, error_d;
`endif

  // cfg_ready_q is registered from the next state, so it is exactly 1 while
  // the current state accepts bits.
  assign xfer = cfg_valid & cfg_ready_q;

  always_comb begin
    state_d   = state_q;
    fuse_d    = fuse_q;
    shadow_d  = shadow_q;
    bit_cnt_d = bit_cnt_q;
    row_idx_d = row_idx_q;
`ifdef FUSE_LOADER_PARITY_EN
    error_d   = error_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_ERASE;
      end
      S_ERASE: begin
        fuse_d    = '1;
        row_idx_d = '0;
        bit_cnt_d = '0;
`ifdef FUSE_LOADER_PARITY_EN
        error_d   = 1'b0;
`endif
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        if (xfer) begin
          shadow_d[bit_cnt_q] = cfg_bit;
          bit_cnt_d           = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(ROW_WIDTH - 1)) begin
`ifdef FUSE_LOADER_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_COMMIT;
`endif
          end
        end
      end
`ifdef FUSE_LOADER_PARITY_EN
      S_PARITY: begin
        if (xfer) begin
          if (((^shadow_q) ^ cfg_bit) != 1'b0) begin
            error_d = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_COMMIT;
          end
        end
      end
`endif
      S_COMMIT: begin
        fuse_d[int'(row_idx_q)*ROW_WIDTH +: ROW_WIDTH] = shadow_q;
        bit_cnt_d = '0;
        if (row_idx_q == IDX_W'(ROWS - 1)) begin
          state_d = S_DONE;
        end else begin
          row_idx_d = row_idx_q + IDX_W'(1);
          state_d   = S_SHIFT;
        end
      end
      S_DONE: begin
        if (start) state_d = S_ERASE;
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered, decoded from the state being entered.
    busy_d      = (state_d == S_ERASE) || (state_d == S_SHIFT) ||
`ifdef FUSE_LOADER_PARITY_EN
                  (state_d == S_PARITY) ||
`endif
                  (state_d == S_COMMIT);
    done_d      = (state_d == S_DONE);
    cfg_ready_d = (state_d == S_SHIFT)
`ifdef FUSE_LOADER_PARITY_EN
                  || (state_d == S_PARITY)
`endif
                  ;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      fuse_q      <= '1;
      shadow_q    <= '0;
      bit_cnt_q   <= '0;
      row_idx_q   <= '0;
      cfg_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef FUSE_LOADER_PARITY_EN
      error_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      fuse_q      <= fuse_d;
      shadow_q    <= shadow_d;
      bit_cnt_q   <= bit_cnt_d;
      row_idx_q   <= row_idx_d;
      cfg_ready_q <= cfg_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef FUSE_LOADER_PARITY_EN
      error_q     <= error_d;
`endif
    end
  end

  assign ptbitmap_mux = fuse_q;
  assign row_idx      = row_idx_q;
  assign cfg_ready    = cfg_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
`ifdef FUSE_LOADER_PARITY_EN
  assign error        = error_q;
`else
  assign error        = 1'b0;
`endif

endmodule

// File: tb/tb_fuse_loader.sv
// Scoreboard bench for fuse_loader with ROWS=2, ROW_WIDTH=8.
// The driver pushes the expected final array / error / row_idx / done latency
// when a load is launched; the monitor pops and compares when done rises.
module tb_fuse_loader;

  localparam int ROWS  = 2;
  localparam int RW    = 8;
  localparam int IDX_W = 1;
`ifdef FUSE_LOADER_PARITY_EN
  localparam int PB    = 1;
`else
  localparam int PB    = 0;
`endif
  localparam int BASE_LAT = 1 + ROWS * (RW + 1 + PB);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic                 cfg_valid = 1'b0;
  logic                 cfg_bit = 1'b0;
  logic                 cfg_ready;
  logic [ROWS*RW-1:0]   ptbitmap_mux;
  logic [IDX_W-1:0]     row_idx;
  logic                 busy;
  logic                 done;
  logic                 error;

  fuse_loader #(.ROWS(ROWS), .ROW_WIDTH(RW), .IDX_W(IDX_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cfg_valid    (cfg_valid),
    .cfg_bit      (cfg_bit),
    .cfg_ready    (cfg_ready),
    .ptbitmap_mux (ptbitmap_mux),
    .row_idx      (row_idx),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  int unsigned start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] fuse;
    logic        err;
    logic [31:0] ridx;
    int unsigned lat;
    bit          exact;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor
  logic        done_prev = 1'b0;
  exp_t        mon_e;
  int unsigned mon_lat;
  always @(negedge clk) begin
    if (rst) begin
      done_prev = 1'b0;
    end else begin
      check("busy_done_exclusive", {31'b0, busy & done}, 32'd0);
      if (done && !done_prev) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done=1 expected no pending load");
        end else begin
          mon_e   = sb.pop_front();
          mon_lat = cyc - start_cyc;
          check("final_fuse", {16'b0, ptbitmap_mux}, {16'b0, mon_e.fuse});
          check("final_error", {31'b0, error}, {31'b0, mon_e.err});
          check("final_row_idx", {31'b0, row_idx}, mon_e.ridx);
          if (mon_e.exact)
            check("done_latency", mon_lat, mon_e.lat);
          else
            check("stall_done_later", {31'b0, (mon_lat > mon_e.lat)}, 32'd1);
        end
      end
      done_prev = done;
    end
  end

  task automatic build(input logic [7:0] r0, input logic [7:0] r1, output logic b[$]);
    b = {};
    for (int i = 0; i < RW; i++) b.push_back(r0[i]);
`ifdef FUSE_LOADER_PARITY_EN
    b.push_back(^r0);
`endif
    for (int i = 0; i < RW; i++) b.push_back(r1[i]);
`ifdef FUSE_LOADER_PARITY_EN
    b.push_back(^r1);
`endif
  endtask

  task automatic push_exp(input logic [15:0] f, input logic e, input int r,
                          input int unsigned lat, input bit exact);
    exp_t x;
    x.fuse = f; x.err = e; x.ridx = r; x.lat = lat; x.exact = exact;
    sb.push_back(x);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
  endtask

  // Presents bits from the start edge on; a bit advances only when it was
  // actually accepted (cfg_valid with cfg_ready seen before the edge).
  task automatic send(input logic b[$], input bit stall, input int stop, input int pulse_at);
    int   idx = 0;
    int   guard = 0;
    bit   pulsed = 0;
    bit   this_pulse;
    logic rdy;
    int   n;
    n = (stop >= 0) ? stop : b.size();
    while (idx < n) begin
      if (guard > 3000) begin
        check("stream_timeout", idx, n);
        break;
      end
      cfg_valid  = stall ? cyc[0] : 1'b1;
      cfg_bit    = b[idx];
      this_pulse = (pulse_at >= 0) && (idx == pulse_at) && !pulsed;
      if (this_pulse) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
      @(negedge clk);
      rdy = cfg_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (cfg_valid && rdy) idx++;
      if (this_pulse) begin
        check("start_busy_still_busy", {31'b0, busy}, 32'd1);
        check("start_busy_row_idx", {31'b0, row_idx}, 32'd1);
      end
      guard++;
    end
    cfg_valid = 1'b0;
  endtask

  task automatic wait_sb();
    int g = 0;
    while (sb.size() != 0 && g < 300) begin
      @(posedge clk);
      g++;
    end
    if (sb.size() != 0) begin
      check("done_timeout", sb.size(), 0);
      sb.delete();
    end
    #1;
  endtask

  logic bits[$];

  initial begin
    #22 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_fuse", {16'b0, ptbitmap_mux}, 32'hFFFF);
    check("reset_cfg_ready", {31'b0, cfg_ready}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_error", {31'b0, error}, 32'd0);
    check("reset_row_idx", {31'b0, row_idx}, 32'd0);

    // Continuous stream: row 0 bit 1 set, row 1 all zero
    build(8'h02, 8'h00, bits);
    do_start();
    push_exp(16'h0002, 1'b0, 1, BASE_LAT, 1'b1);
    send(bits, 1'b0, -1, -1);
    wait_sb();

    // Same stream with cfg_valid low every other cycle
    do_start();
    push_exp(16'h0002, 1'b0, 1, BASE_LAT, 1'b0);
    send(bits, 1'b1, -1, -1);
    wait_sb();

    // Different pattern in both rows
    build(8'hA5, 8'h3C, bits);
    do_start();
    push_exp(16'h3CA5, 1'b0, 1, BASE_LAT, 1'b1);
    send(bits, 1'b0, -1, -1);
    wait_sb();

    // start pulsed during SHIFT of row 1 has no effect
    build(8'h02, 8'h00, bits);
    do_start();
    push_exp(16'h0002, 1'b0, 1, BASE_LAT, 1'b1);
    send(bits, 1'b0, -1, 12);
    wait_sb();

`ifdef FUSE_LOADER_PARITY_EN
    // Row 0 = bit 0 set with parity bit 0: error, abort, array stays erased
    bits = {};
    bits.push_back(1'b1);
    for (int i = 1; i < RW; i++) bits.push_back(1'b0);
    bits.push_back(1'b0);
    do_start();
    push_exp(16'hFFFF, 1'b1, 0, 1 + RW + 1, 1'b1);
    send(bits, 1'b0, -1, -1);
    wait_sb();

    // Next good load clears the sticky error
    build(8'hA5, 8'h3C, bits);
    do_start();
    push_exp(16'h3CA5, 1'b0, 1, BASE_LAT, 1'b1);
    send(bits, 1'b0, -1, -1);
    wait_sb();
`endif

    // Reset after 5 bits of row 1
    build(8'hA5, 8'h3C, bits);
    do_start();
    send(bits, 1'b0, RW + PB + 5, -1);
    check("pre_reset_row0", {24'b0, ptbitmap_mux[7:0]}, 32'hA5);
    #2 rst = 1'b1;
    #1;
    check("midrst_fuse", {16'b0, ptbitmap_mux}, 32'hFFFF);
    check("midrst_cfg_ready", {31'b0, cfg_ready}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_row_idx", {31'b0, row_idx}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle_ready", {31'b0, cfg_ready}, 32'd0);

    build(8'h02, 8'h00, bits);
    do_start();
    push_exp(16'h0002, 1'b0, 1, BASE_LAT, 1'b1);
    send(bits, 1'b0, -1, -1);
    wait_sb();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
